ofdm_cp_remover: RTL and testbench

- Sits directly downstream of the Schmidl-Cox detector, in the ce_clk domain of the OFDM RX chain, and feeds the FFT stage.
- Waits for a frame-start flag on the input stream, then processes a configured number of OFDM symbols. For each symbol it discards the cyclic prefix and forwards exactly FFT-size samples, with tlast on the last sample of every symbol.
- Samples outside a frame are dropped.

---
 rtl/ofdm_cp_remover_if.sv | 13 +
 rtl/ofdm_cp_remover.sv | 194 +++++++++++++++++++
 tb/tb_ofdm_cp_remover.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ofdm_cp_remover_if.sv
// rtl/ofdm_cp_remover_if.sv - sample stream bundle used on both sides of the CP remover
interface ofdm_cp_remover_if #(
  parameter int ITEM_W = 32
);
  logic [ITEM_W-1:0] tdata;
  logic              tuser;
  logic              tlast;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, tuser, tlast, tvalid, input tready);
  modport slave  (input tdata, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/ofdm_cp_remover.sv
// rtl/ofdm_cp_remover.sv - strips the cyclic prefix from each OFDM symbol of a frame
// and forwards FFT-size symbols with tlast per symbol and tuser on the first frame sample.
module ofdm_cp_remover #(
  parameter int ITEM_W       = 32,
  parameter int MAX_FFT_LOG2 = 12,
  parameter int CP_W         = 12,
  parameter int SYM_W        = 16
) (
  input  logic                  ce_clk,
  input  logic                  ce_rst,
  input  logic [3:0]            cfg_fft_log2,
  input  logic [CP_W-1:0]       cfg_cp_len,
  input  logic [SYM_W-1:0]      cfg_num_symbols,
  ofdm_cp_remover_if.slave      s_axis,
  ofdm_cp_remover_if.master     m_axis,
  output logic                  frame_active,
  output logic [SYM_W-1:0]      sym_count,
  output logic [15:0]           ignored_starts
);

  typedef enum logic [1:0] {IDLE, CP, DATA} state_t;

  localparam logic [3:0] MIN_LOG2 = 4'd3;
  localparam logic [3:0] MAX_LOG2 = 4'(MAX_FFT_LOG2);

  state_t state, state_n;

  logic [3:0]              fft_log2_r;
  logic [3:0]              fft_log2_clamped;
  logic [CP_W-1:0]         cp_len_r;
  logic [SYM_W-1:0]        num_sym_r;
  logic [CP_W-1:0]         cp_cnt;
  logic [MAX_FFT_LOG2-1:0] samp_cnt;
  logic [MAX_FFT_LOG2-1:0] last_idx;

  logic [ITEM_W-1:0] m_data_r;
  logic              m_valid_r;
  logic              m_last_r;
  logic              m_user_r;

  logic s_ready;
  logic take;
  logic fwd;
  logic fwd_user;
  logic fwd_last;
  logic out_free;
  logic frame_end;
  logic unused_tlast;

  assign unused_tlast = s_axis.tlast;

  always_comb begin
    fft_log2_clamped = cfg_fft_log2;
    if (cfg_fft_log2 < MIN_LOG2) begin
      fft_log2_clamped = MIN_LOG2;
    end else if (cfg_fft_log2 > MAX_LOG2) begin
      fft_log2_clamped = MAX_LOG2;
    end
  end

  assign last_idx  = {MAX_FFT_LOG2{1'b1}} >> (MAX_LOG2 - fft_log2_r);
  assign out_free  = !m_valid_r || m_axis.tready;
  assign frame_end = (num_sym_r != '0) && (sym_count == num_sym_r - SYM_W'(1));

  always_ff @(posedge ce_clk) begin
    if (ce_rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    s_ready  = 1'b0;
    take     = 1'b0;
    fwd      = 1'b0;
    fwd_user = 1'b0;
    fwd_last = 1'b0;
    if (!ce_rst) begin
      unique case (state)
        IDLE: begin
          // A zero-CP start beat is forwarded, so it must wait for room in the output register.
          s_ready = (cfg_cp_len != '0) || out_free;
          take    = s_axis.tvalid && s_ready;
          if (take && s_axis.tuser) begin
            if (cfg_cp_len == '0) begin
              fwd      = 1'b1;
              fwd_user = 1'b1;
              state_n  = DATA;
            end else if (cfg_cp_len == CP_W'(1)) begin
              state_n = DATA;
            end else begin
              state_n = CP;
            end
          end
        end
        CP: begin
          s_ready = 1'b1;
          take    = s_axis.tvalid;
          if (take && (cp_cnt == cp_len_r - CP_W'(1))) begin
            state_n = DATA;
          end
        end
        DATA: begin
          s_ready = out_free;
          take    = s_axis.tvalid && s_ready;
          if (take) begin
            fwd      = 1'b1;
            fwd_user = (samp_cnt == '0) && (sym_count == '0);
            fwd_last = (samp_cnt == last_idx);
            if (fwd_last) begin
              if (frame_end) begin
                state_n = IDLE;
              end else if (cp_len_r == '0) begin
                state_n = DATA;
              end else begin
                state_n = CP;
              end
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge ce_clk) begin
    if (ce_rst) begin
      fft_log2_r     <= MIN_LOG2;
      cp_len_r       <= '0;
      num_sym_r      <= '0;
      cp_cnt         <= '0;
      samp_cnt       <= '0;
      sym_count      <= '0;
      ignored_starts <= '0;
      m_data_r       <= '0;
      m_valid_r      <= 1'b0;
      m_last_r       <= 1'b0;
      m_user_r       <= 1'b0;
    end else begin
      if (m_valid_r && m_axis.tready) begin
        m_valid_r <= 1'b0;
      end
      if (fwd) begin
        m_data_r  <= s_axis.tdata;
        m_last_r  <= fwd_last;
        m_user_r  <= fwd_user;
        m_valid_r <= 1'b1;
      end
      if (take && s_axis.tuser && (state != IDLE) && (ignored_starts != 16'hFFFF)) begin
        ignored_starts <= ignored_starts + 16'd1;
      end
      if (take) begin
        unique case (state)
          IDLE: begin
            if (s_axis.tuser) begin
              fft_log2_r <= fft_log2_clamped;
              cp_len_r   <= cfg_cp_len;
              num_sym_r  <= cfg_num_symbols;
              cp_cnt     <= CP_W'(1);
              samp_cnt   <= (cfg_cp_len == '0) ? MAX_FFT_LOG2'(1) : '0;
              sym_count  <= '0;
            end
          end
          CP: begin
            cp_cnt   <= cp_cnt + CP_W'(1);
            samp_cnt <= '0;
          end
          DATA: begin
            if (fwd_last) begin
              samp_cnt <= '0;
              cp_cnt   <= '0;
              if (state_n != IDLE) begin
                sym_count <= sym_count + SYM_W'(1);
              end
            end else begin
              samp_cnt <= samp_cnt + MAX_FFT_LOG2'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign s_axis.tready = s_ready;
  assign m_axis.tdata  = m_data_r;
  assign m_axis.tvalid = m_valid_r;
  assign m_axis.tlast  = m_last_r;
  assign m_axis.tuser  = m_user_r;
  assign frame_active  = (state != IDLE);

endmodule

// File: tb/tb_ofdm_cp_remover.sv
// tb/tb_ofdm_cp_remover.sv - directed and randomized frames for ofdm_cp_remover
// checked against an arithmetic symbol/CP position model.
module tb_ofdm_cp_remover;
  localparam int ITEM_W = 32;
  localparam int CP_W   = 12;
  localparam int SYM_W  = 16;

  logic              ce_clk = 1'b0;
  logic              ce_rst = 1'b1;
  logic [3:0]        cfg_fft_log2 = 4'd6;
  logic [CP_W-1:0]   cfg_cp_len = 12'd16;
  logic [SYM_W-1:0]  cfg_num_symbols = 16'd2;
  logic              frame_active;
  logic [SYM_W-1:0]  sym_count;
  logic [15:0]       ignored_starts;

  ofdm_cp_remover_if #(.ITEM_W(ITEM_W)) s_axis ();
  ofdm_cp_remover_if #(.ITEM_W(ITEM_W)) m_axis ();

  ofdm_cp_remover dut (
    .ce_clk          (ce_clk),
    .ce_rst          (ce_rst),
    .cfg_fft_log2    (cfg_fft_log2),
    .cfg_cp_len      (cfg_cp_len),
    .cfg_num_symbols (cfg_num_symbols),
    .s_axis          (s_axis),
    .m_axis          (m_axis),
    .frame_active    (frame_active),
    .sym_count       (sym_count),
    .ignored_starts  (ignored_starts)
  );

  always #5 ce_clk = ~ce_clk;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
    logic        u;
  } beat_t;

  int    checks = 0;
  int    errors = 0;
  bit    bp_en = 1'b0;
  int    gap_pct = 0;
  beat_t got[$];
  beat_t exp_q[$];
  logic [31:0] in_d[$];
  bit    in_u[$];
  int    exp_ign_total = 0;
  int    model_ign;
  int    model_last_sym;
  bit    model_active;
  int    last_sym_at_accept;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Output monitor: records accepted beats and checks that stalled beats hold.
  bit          stalled = 1'b0;
  logic [33:0] held;
  always @(negedge ce_clk) begin
    if (ce_rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled)
        check("stall_hold", {m_axis.tvalid, m_axis.tdata, m_axis.tlast, m_axis.tuser}, {1'b1, held});
      if (m_axis.tvalid && m_axis.tready)
        got.push_back('{d: m_axis.tdata, l: m_axis.tlast, u: m_axis.tuser});
      stalled = m_axis.tvalid && !m_axis.tready;
      held    = {m_axis.tdata, m_axis.tlast, m_axis.tuser};
    end
  end

  initial begin
    m_axis.tready = 1'b1;
    forever begin
      @(posedge ce_clk);
      #1;
      m_axis.tready = bp_en ? 1'($urandom_range(1, 0)) : 1'b1;
    end
  end

  task automatic build_frame(input int nidle, input int nframe, input int mid_idx, input bit ramp);
    in_d.delete();
    in_u.delete();
    for (int i = 0; i < nidle; i++) begin
      in_d.push_back($urandom);
      in_u.push_back(1'b0);
    end
    for (int j = 0; j < nframe; j++) begin
      in_d.push_back(ramp ? 32'(j) : $urandom);
      in_u.push_back((j == 0) || (j == mid_idx));
    end
  endtask

  // Each in-frame beat sits at offset off = sym*(cp+N) + pos; pos < cp is prefix.
  task automatic run_model(input int log2, input int cp, input int nsym);
    int n, f, off, sym, pos;
    bit started;
    n = 1 << ((log2 < 3) ? 3 : (log2 > 12) ? 12 : log2);
    exp_q.delete();
    model_ign = 0;
    started = 1'b0;
    f = 0;
    for (int i = 0; i < in_d.size(); i++) begin
      if (started && nsym != 0 && (i - f) / (cp + n) >= nsym) started = 1'b0;
      if (!started) begin
        if (!in_u[i]) continue;
        started = 1'b1;
        f = i;
      end else if (in_u[i]) begin
        model_ign++;
      end
      off = i - f;
      sym = off / (cp + n);
      pos = off % (cp + n);
      model_last_sym = sym;
      if (pos >= cp)
        exp_q.push_back('{d: in_d[i], l: (pos - cp == n - 1), u: (sym == 0 && pos == cp)});
    end
    model_active = started && !(nsym != 0 && (in_d.size() - f) / (cp + n) >= nsym);
  endtask

  task automatic send_all(input int abort_at);
    bit rdy, ok;
    int sc;
    for (int i = 0; i < in_d.size(); i++) begin
      if (abort_at > 0 && got.size() >= abort_at) break;
      if ($urandom_range(99, 0) < gap_pct) begin
        s_axis.tvalid = 1'b0;
        @(posedge ce_clk);
        #1;
      end
      s_axis.tdata  = in_d[i];
      s_axis.tuser  = in_u[i];
      s_axis.tlast  = 1'($urandom_range(1, 0));
      s_axis.tvalid = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 2000; c++) begin
        @(negedge ce_clk);
        rdy = s_axis.tready;
        sc  = int'(sym_count);
        @(posedge ce_clk);
        #1;
        if (rdy) begin
          ok = 1'b1;
          break;
        end
      end
      s_axis.tvalid = 1'b0;
      s_axis.tuser  = 1'b0;
      last_sym_at_accept = sc;
      if (!ok) begin
        check("input_accept_timeout", 64'(ok), 64'd1);
        break;
      end
    end
  endtask

  task automatic compare(input string tag);
    int n;
    for (int c = 0; c < 20000 && got.size() < exp_q.size(); c++) @(posedge ce_clk);
    repeat (8) @(posedge ce_clk);
    #1;
    check({tag, "_count"}, 64'(got.size()), 64'(exp_q.size()));
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int k = 0; k < n; k++)
      check($sformatf("%s_beat%0d", tag, k), 64'(got[k]), 64'(exp_q[k]));
    check({tag, "_frame_active"}, 64'(frame_active), 64'(model_active));
    check({tag, "_sym_at_last_beat"}, 64'(last_sym_at_accept), 64'(model_last_sym));
    exp_ign_total += model_ign;
    check({tag, "_ignored_starts"}, 64'(ignored_starts), 64'(exp_ign_total));
    got.delete();
  endtask

  task automatic run_frame(input string tag, input int log2, input int cp, input int nsym,
                           input int nidle, input int nframe, input int mid_idx, input bit ramp);
    cfg_fft_log2    = 4'(log2);
    cfg_cp_len      = CP_W'(cp);
    cfg_num_symbols = SYM_W'(nsym);
    build_frame(nidle, nframe, mid_idx, ramp);
    run_model(log2, cp, nsym);
    send_all(0);
    compare(tag);
  endtask

  initial begin
    int l2, cp, ns;
    s_axis.tdata  = '0;
    s_axis.tuser  = 1'b0;
    s_axis.tlast  = 1'b0;
    s_axis.tvalid = 1'b0;
    ce_rst = 1'b1;
    repeat (2) @(posedge ce_clk);
    @(negedge ce_clk);
    check("rst_s_tready", 64'(s_axis.tready), 64'd0);
    check("rst_m_tvalid", 64'(m_axis.tvalid), 64'd0);
    @(posedge ce_clk);
    #1;
    ce_rst = 1'b0;
    @(negedge ce_clk);
    check("rst_outputs", {m_axis.tlast, m_axis.tuser, frame_active}, 64'd0);
    check("rst_sym_count", 64'(sym_count), 64'd0);
    check("rst_ignored", 64'(ignored_starts), 64'd0);
    check("idle_s_tready", 64'(s_axis.tready), 64'd1);
    @(posedge ce_clk);
    #1;

    run_frame("baseline", 6, 16, 2, 10, 160, -1, 1'b1);
    run_frame("zero_cp", 3, 0, 3, 5, 24, -1, 1'b1);

    bp_en = 1'b1;
    gap_pct = 25;
    run_frame("backpressure", 6, 16, 2, 10, 160, -1, 1'b1);
    bp_en = 1'b0;
    gap_pct = 0;

    run_frame("mid_start", 6, 16, 2, 10, 160, 40, 1'b1);

    bp_en = 1'b1;
    gap_pct = 20;
    for (int r = 0; r < 3; r++) begin
      l2 = $urandom_range(5, 0);
      cp = $urandom_range(9, 0);
      ns = $urandom_range(3, 1);
      run_frame($sformatf("random%0d", r), l2, cp, ns, 3,
                ns * (cp + (1 << ((l2 < 3) ? 3 : l2))), -1, 1'b0);
    end
    bp_en = 1'b0;
    gap_pct = 0;

    run_frame("clamp_high", 15, 3, 1, 2, 4099, -1, 1'b0);

    cfg_fft_log2    = 4'd6;
    cfg_cp_len      = 12'd16;
    cfg_num_symbols = 16'd2;
    build_frame(10, 160, -1, 1'b1);
    send_all(30);
    ce_rst = 1'b1;
    @(negedge ce_clk);
    check("midrst_s_tready", 64'(s_axis.tready), 64'd0);
    @(posedge ce_clk);
    #1;
    ce_rst = 1'b0;
    @(negedge ce_clk);
    check("midrst_outputs", {m_axis.tvalid, m_axis.tdata, m_axis.tlast, m_axis.tuser, frame_active}, 64'd0);
    check("midrst_sym_count", 64'(sym_count), 64'd0);
    check("midrst_ignored", 64'(ignored_starts), 64'd0);
    got.delete();
    exp_ign_total = 0;
    @(posedge ce_clk);
    #1;
    run_frame("after_reset", 6, 16, 2, 10, 160, -1, 1'b1);

    run_frame("continuous", 3, 2, 0, 4, 50, -1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
